// File: rtl/bus_arbiter_rr4.sv
// bus_arbiter_rr4: round-robin owner arbiter for the 4:1 16-bit shared-bus mux.
//
// Requesters (0=CPU, 1=video, 2=paddle/ball, 3=I/O) raise req; one owner at a time is
// granted and the mux select is driven from the same registered decision. An owner can
// be force-released after MAX_HOLD consecutive cycles (0 = unlimited), and an optional
// idle gap of TURNAROUND cycles separates successive grants.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high
//   req        in   4  req[i]=1: requester i wants / still uses the bus
//   grant      out  4  registered one-hot (or zero) grant
//   mux_sel    out  2  mux select, index of the current/last owner
//   bus_valid  out  1  |grant
//   timeout    out  1  one-cycle pulse on a forced (MAX_HOLD) release
module bus_arbiter_rr4 #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] mux_sel,
    output logic       bus_valid,
    output logic       timeout
);

    localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
    // Gap counter loads TURNAROUND-1; only meaningful when TURNAROUND > 0.
    localparam logic [2:0] GapInit = (TURNAROUND > 0) ? 3'(TURNAROUND - 1) : 3'd0;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       mux_sel_q, mux_sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [2:0]       gap_q, gap_d;
    logic             timeout_q, timeout_d;

    logic [2:0] pick_idle;
    logic [2:0] pick_next;
    logic       own_req;
    logic       at_limit;

    // Returns {found, index} of the first set request searching p, p+1, p+2, p+3 (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        // Walk from lowest priority to highest so the highest-priority hit wins.
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick_idle = rr_pick(req, ptr_q);
        // After a release the pointer moves to owner+1; used for back-to-back re-arbitration.
        pick_next = rr_pick(req, mux_sel_q + 2'd1);
        own_req   = req[mux_sel_q];
        at_limit  = (MAX_HOLD != 0) && (hold_q == HoldMax);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        mux_sel_d = mux_sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                if (pick_idle[2]) begin
                    grant_d   = 4'(4'b0001 << pick_idle[1:0]);
                    mux_sel_d = pick_idle[1:0];
                    hold_d    = HoldW'(1);
                    state_d   = StGrant;
                end
            end
            StGrant: begin
                if (!own_req || at_limit) begin
                    // Still requesting means the release was forced by the hold limit.
                    timeout_d = own_req;
                    ptr_d     = mux_sel_q + 2'd1;
                    if (TURNAROUND > 0) begin
                        grant_d = '0;
                        gap_d   = GapInit;
                        state_d = StGap;
                    end else if (pick_next[2]) begin
                        grant_d   = 4'(4'b0001 << pick_next[1:0]);
                        mux_sel_d = pick_next[1:0];
                        hold_d    = HoldW'(1);
                    end else begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end else if (MAX_HOLD != 0) begin
                    // Cannot pass HoldMax: reaching it forces a release above.
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StGap: begin
                grant_d = '0;
                if (gap_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            mux_sel_q <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            mux_sel_q <= mux_sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign mux_sel   = mux_sel_q;
    assign bus_valid = |grant_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Bench for bus_arbiter_rr4: four instances with different MAX_HOLD/TURNAROUND share one
// stimulus and are each compared every cycle against a behavioural reference model.
module tb_bus_arbiter_rr4;

    localparam int MH [4] = '{16, 4, 4, 0};
    localparam int TA [4] = '{1, 1, 0, 2};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;

    logic [3:0] grant_w   [4];
    logic [1:0] mux_sel_w [4];
    logic       valid_w   [4];
    logic       tmo_w     [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: owner index or -1, cycles held, gap cycles left, pointer.
    int m_owner [4];
    int m_sel   [4];
    int m_ptr   [4];
    int m_hold  [4];
    int m_gap   [4];
    bit m_tmo   [4];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        bus_arbiter_rr4 #(
            .MAX_HOLD  (MH[k]),
            .TURNAROUND(TA[k])
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req      (req),
            .grant    (grant_w[k]),
            .mux_sel  (mux_sel_w[k]),
            .bus_valid(valid_w[k]),
            .timeout  (tmo_w[k])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic grab(input int k);
        int w;
        w = pick(req, m_ptr[k]);
        if (w >= 0) begin
            m_owner[k] = w;
            m_sel[k]   = w;
            m_hold[k]  = 1;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            bit still;
            bit lim;
            m_tmo[k] = 1'b0;
            if (reset) begin
                m_owner[k] = -1;
                m_sel[k]   = 0;
                m_ptr[k]   = 0;
                m_hold[k]  = 0;
                m_gap[k]   = 0;
            end else if (m_owner[k] >= 0) begin
                still = req[m_owner[k]];
                lim   = (MH[k] != 0) && (m_hold[k] >= MH[k]);
                if (!still || lim) begin
                    m_tmo[k]   = still;
                    m_ptr[k]   = (m_owner[k] + 1) % 4;
                    m_owner[k] = -1;
                    if (TA[k] > 0) m_gap[k] = TA[k];
                    else grab(k);
                end else begin
                    m_hold[k]++;
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else begin
                grab(k);
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0] eg;
        for (int k = 0; k < 4; k++) begin
            eg = (m_owner[k] >= 0) ? 4'(4'b0001 << m_owner[k]) : 4'b0000;
            check_eq($sformatf("u%0d.grant", k), 32'(grant_w[k]), 32'(eg));
            check_eq($sformatf("u%0d.mux_sel", k), 32'(mux_sel_w[k]), 32'(m_sel[k]));
            check_eq($sformatf("u%0d.bus_valid", k), 32'(valid_w[k]), 32'(m_owner[k] >= 0));
            check_eq($sformatf("u%0d.timeout", k), 32'(tmo_w[k]), 32'(m_tmo[k]));
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_owner[k] = -1; m_sel[k] = 0; m_ptr[k] = 0;
            m_hold[k]  = 0;  m_gap[k] = 0; m_tmo[k] = 1'b0;
        end
        reset = 1'b1;
        req   = 4'b1111;

        // Reset held with every request raised.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst.grant", 32'(grant_w[0]), 32'h0);
            check_eq("rst.sel", 32'(mux_sel_w[0]), 32'h0);
            check_eq("rst.valid", 32'(valid_w[0]), 32'h0);
            check_eq("rst.timeout", 32'(tmo_w[0]), 32'h0);
        end

        // Basic grant, release, gap, idle, next grant (u0: defaults).
        reset = 1'b0;
        req   = 4'b0101;
        tick();
        check_eq("basic.grant0", 32'(grant_w[0]), 32'h1);
        check_eq("basic.sel0", 32'(mux_sel_w[0]), 32'h0);
        req = 4'b0100;
        tick();
        check_eq("basic.gap", 32'(grant_w[0]), 32'h0);
        tick();
        check_eq("basic.idle", 32'(grant_w[0]), 32'h0);
        tick();
        check_eq("basic.grant2", 32'(grant_w[0]), 32'h4);
        check_eq("basic.sel2", 32'(mux_sel_w[0]), 32'h2);

        // Hold limit rotation on u1 (MAX_HOLD=4, TURNAROUND=1).
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                if (c > 0) tick();
                check_eq("hold.grant", 32'(grant_w[1]), 32'(4'b0001 << (g % 4)));
                check_eq("hold.notmo", 32'(tmo_w[1]), 32'h0);
            end
            tick();
            check_eq("hold.gap", 32'(grant_w[1]), 32'h0);
            check_eq("hold.timeout", 32'(tmo_w[1]), 32'h1);
            tick();
            check_eq("hold.idle", 32'(grant_w[1]), 32'h0);
            tick();
        end

        // Back-to-back handover on u2 (TURNAROUND=0).
        do_reset();
        req = 4'b0011;
        tick();
        check_eq("b2b.first", 32'(grant_w[2]), 32'h1);
        tick();
        check_eq("b2b.second", 32'(grant_w[2]), 32'h1);
        req = 4'b0010;
        tick();
        check_eq("b2b.handover", 32'(grant_w[2]), 32'h2);
        check_eq("b2b.sel", 32'(mux_sel_w[2]), 32'h1);

        // Reset mid-grant on u0, then pointer is back at 0.
        do_reset();
        req = 4'b0100;
        tick();
        check_eq("midrst.grant", 32'(grant_w[0]), 32'h4);
        tick();
        reset = 1'b1;
        tick();
        check_eq("midrst.cleared", 32'(grant_w[0]), 32'h0);
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        check_eq("midrst.ptr0", 32'(grant_w[0]), 32'h1);

        // Unlimited hold on u3 (MAX_HOLD=0).
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 101; c++) begin
            tick();
            check_eq("unlim.grant", 32'(grant_w[3]), 32'h2);
            check_eq("unlim.timeout", 32'(tmo_w[3]), 32'h0);
        end

        // Randomized traffic with occasional resets, model-checked on every instance.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
